// File: rtl/dm_icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: bus encodings,
// address width, default geometry and the miss-handling state type.
package dm_icache_pkg;

   localparam int XLEN         = 32;
   localparam int ICACHE_LINES = 32;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } icache_state_t;

endpackage

// File: rtl/dm_icache_mem.sv
// Line array for the instruction cache: asynchronous read, synchronous write,
// and valid bits that are the only state cleared by reset.
module dm_icache_mem #(
   parameter int NUM_LINES = 32,
   parameter int IDX_W     = 5,
   parameter int TAG_W     = 24
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [63:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [63:0]      wr_data
);

   logic [NUM_LINES-1:0] valid_bits;
   logic [TAG_W-1:0]     tags  [NUM_LINES];
   logic [63:0]          lines [NUM_LINES];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_bits <= '0;
      end else if (wr_en) begin
         valid_bits[wr_idx] <= 1'b1;
      end
   end

   // Tag and data storage is deliberately left unreset; the valid bit guards it.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         tags[wr_idx]  <= wr_tag;
         lines[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_bits[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = lines[rd_idx];

endmodule

// File: rtl/dm_icache.sv
// Direct-mapped blocking instruction cache: combinational hit path toward fetch
// and a single outstanding tagged load toward instruction memory.
module dm_icache
   import dm_icache_pkg::*;
#(
   parameter int NUM_LINES = ICACHE_LINES
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] proc2Icache_addr,
   output logic [63:0]     Icache_data_out,
   output logic            Icache_valid_out,
   output logic [1:0]      proc2Imem_command,
   output logic [XLEN-1:0] proc2Imem_addr,
   input  logic [3:0]      Imem2proc_response,
   input  logic [63:0]     Imem2proc_data,
   input  logic [3:0]      Imem2proc_tag
);

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = XLEN - IDX_W - 3;

   icache_state_t    state, next_state;
   logic [3:0]       pend_bus_tag;
   logic [IDX_W-1:0] pend_idx;
   logic [TAG_W-1:0] pend_tag;

   logic [IDX_W-1:0] addr_idx;
   logic [TAG_W-1:0] addr_tag;
   logic [2:0]       unused_offset;
   logic             line_valid;
   logic [TAG_W-1:0] line_tag;
   logic [63:0]      line_data;
   logic             hit, issue, accept, fill;

   assign addr_idx      = proc2Icache_addr[IDX_W+2:3];
   assign addr_tag      = proc2Icache_addr[XLEN-1:IDX_W+3];
   assign unused_offset = proc2Icache_addr[2:0];

   dm_icache_mem #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) lines (
      .clock    (clock),
      .reset    (reset),
      .rd_idx   (addr_idx),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (fill),
      .wr_idx   (pend_idx),
      .wr_tag   (pend_tag),
      .wr_data  (Imem2proc_data)
   );

   assign hit    = line_valid && (line_tag == addr_tag);
   assign issue  = (state == IDLE) && !hit;
   assign accept = issue && (Imem2proc_response != 4'd0);
   // Tag 0 means "no data", so it can never complete a fill.
   assign fill   = (state == WAIT) && (Imem2proc_tag != 4'd0) &&
                   (Imem2proc_tag == pend_bus_tag);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pend_bus_tag <= '0;
         pend_idx     <= '0;
         pend_tag     <= '0;
      end else if (accept) begin
         pend_bus_tag <= Imem2proc_response;
         pend_idx     <= addr_idx;
         pend_tag     <= addr_tag;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = WAIT;
         WAIT:    if (fill)   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs are forced to their idle values while reset is held low.
   always_comb begin
      Icache_valid_out  = 1'b0;
      Icache_data_out   = '0;
      proc2Imem_command = BUS_NONE;
      proc2Imem_addr    = '0;
      if (reset) begin
         Icache_valid_out = hit;
         Icache_data_out  = hit ? line_data : 64'd0;
         if (issue) begin
            proc2Imem_command = BUS_LOAD;
            proc2Imem_addr    = {proc2Icache_addr[XLEN-1:3], 3'b000};
         end
      end
   end

endmodule
